// File: rtl/seg_scan_mux_pkg.sv
// seg_scan_mux_pkg: glyph table, blank constants and scan FSM encoding
package seg_scan_mux_pkg;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };
  typedef enum logic {ST_BLANK, ST_ON} st_t;
endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: digit data in, segment/anode drive out
interface seg_scan_mux_if;
  logic [15:0] bcd_in;
  logic [3:0] dp_in;
  logic lz_en;
  logic [7:0] seg;
  logic [3:0] an;
  logic frame_start;
  modport master(output bcd_in, dp_in, lz_en, input seg, an, frame_start);
  modport slave(input bcd_in, dp_in, lz_en, output seg, an, frame_start);
endinterface

// File: rtl/seg_glyph_dec.sv
// seg_glyph_dec: hex digit to {a..g,dp} segment pattern
module seg_glyph_dec
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] d,
  output logic [7:0] seg
);
  assign seg = GLYPH[d];
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 4-digit multiplexed 7-segment scanner with blanking and leading-zero suppression
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 10000,
  parameter int BLANK_CYCLES = 100
) (
  input logic clk,
  input logic rst,
  seg_scan_mux_if.slave io
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BC = CW'(BLANK_CYCLES);
  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad
    $error("BLANK_CYCLES must be smaller than REFRESH_DIV");
  end
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] idx, idx_nxt;
  st_t st, st_nxt;
  logic [15:0] fb, bcd;
  logic [3:0] fd, dp, dig, an_nxt;
  logic fl, lz, snap, slot_end, sup;
  logic [7:0] g, seg_nxt;
  seg_glyph_dec u_dec (.d(dig), .seg(g));
  // the snapshot cycle decodes straight from the inputs so the frame's first ON cycle is never stale
  always_comb begin
    slot_end = cnt == TC;
    cnt_nxt = slot_end ? '0 : cnt + CW'(1);
    idx_nxt = slot_end ? idx + 2'd1 : idx;
    st_nxt = cnt_nxt < BC ? ST_BLANK : ST_ON;
    snap = cnt == '0 && idx == 2'd0;
    bcd = snap ? io.bcd_in : fb;
    dp = snap ? io.dp_in : fd;
    lz = snap ? io.lz_en : fl;
    dig = bcd[idx*4 +: 4];
    sup = lz && idx != 2'd0 && (bcd >> {idx, 2'b00}) == '0;
    seg_nxt = st == ST_ON ? {sup ? 7'd0 : g[7:1], dp[idx]} : SEG_BLANK;
    an_nxt = st == ST_ON ? ~(4'b0001 << idx) : AN_OFF;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
      st <= ST_BLANK;
      fb <= '0;
      fd <= '0;
      fl <= 1'b0;
      io.seg <= SEG_BLANK;
      io.an <= AN_OFF;
      io.frame_start <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      st <= st_nxt;
      if (snap) begin
        fb <= io.bcd_in;
        fd <= io.dp_in;
        fl <= io.lz_en;
      end
      io.seg <= seg_nxt;
      io.an <= an_nxt;
      io.frame_start <= snap;
    end
  end
endmodule
